// File: rtl/rocket_frame_readout.sv
// Rocket telemetry frame serializer: snapshots NWORDS data words at frame start, frames them
// with an optional sync header and modular checksum, and shifts bits out on gclk/load edges.
module rocket_frame_readout #(
  parameter int                WIDTH     = 10,
  parameter int                NWORDS    = 52,
  parameter bit                SYNC_EN   = 1'b1,
  parameter logic [WIDTH-1:0]  SYNC_WORD = 10'h3A5,
  parameter bit                CKSUM_EN  = 1'b1,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0]  IDLE_WORD = '0,
  localparam int               NSLOTS    = NWORDS + int'(SYNC_EN) + int'(CKSUM_EN),
  localparam int               IDXW      = (NSLOTS > 1) ? $clog2(NSLOTS) : 1
) (
  input  logic                     clk50,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     gclk,
  input  logic                     load,
  input  logic                     frame_clr,
  input  logic [NWORDS*WIDTH-1:0]  words_in,
  output logic                     serial_out,
  output logic [IDXW-1:0]          slot_idx,
  output logic                     word_strobe,
  output logic                     frame_done,
  output logic                     ovr_err
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLOTS - 1);

  logic                     gclk_d, load_d;
  logic [WIDTH-1:0]         shreg;
  logic [BW-1:0]            bits_left;
  logic [WIDTH-1:0]         cksum;
  logic                     last_flag;
  logic [NWORDS*WIDTH-1:0]  snap_buf;

  logic                     gclk_rise, load_rise;
  logic                     is_sync, is_data;
  logic [IDXW-1:0]          data_pos, dsel;
  logic [NWORDS*WIDTH-1:0]  data_src;
  logic [WIDTH-1:0]         data_word, slot_val, cksum_base;

  assign gclk_rise  = gclk & ~gclk_d;
  assign load_rise  = load & ~load_d;
  assign serial_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

  always_comb begin
    is_sync  = SYNC_EN && (slot_idx == '0);
    data_pos = slot_idx - IDXW'(SYNC_EN);
    is_data  = !is_sync && (int'(data_pos) < NWORDS);
    dsel     = is_data ? data_pos : '0;
    // Slot 0 can only be a data slot without sync; it must see words_in before the snapshot lands.
    data_src  = (slot_idx == '0) ? words_in : snap_buf;
    data_word = data_src[int'(dsel)*WIDTH +: WIDTH];
    if (is_sync)      slot_val = SYNC_WORD;
    else if (is_data) slot_val = data_word;
    else              slot_val = cksum;
    cksum_base = (slot_idx == '0) ? '0 : cksum;
  end

  always_ff @(posedge clk50) begin
    word_strobe <= 1'b0;
    frame_done  <= 1'b0;
    if (rst) begin
      gclk_d    <= 1'b0;
      load_d    <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      cksum     <= '0;
      last_flag <= 1'b0;
      snap_buf  <= '0;
      slot_idx  <= '0;
      ovr_err   <= 1'b0;
    end else begin
      gclk_d <= gclk;
      load_d <= load;
      if (frame_clr) begin
        shreg     <= '0;
        bits_left <= '0;
        cksum     <= '0;
        last_flag <= 1'b0;
        slot_idx  <= '0;
        ovr_err   <= 1'b0;
      end else if (load_rise) begin
        bits_left <= BW'(WIDTH);
        if (enable) begin
          shreg <= slot_val;
          if (bits_left != '0) ovr_err <= 1'b1;
          if (slot_idx == LAST_IDX) begin
            slot_idx  <= '0;
            last_flag <= 1'b1;
          end else begin
            slot_idx <= slot_idx + 1'b1;
          end
          if (slot_idx == '0) snap_buf <= words_in;
          if (is_data) begin
            cksum       <= cksum_base + data_word;
            word_strobe <= 1'b1;
          end else if (slot_idx == '0) begin
            cksum <= '0;
          end
        end else begin
          shreg <= IDLE_WORD;
        end
      end else if (gclk_rise && bits_left != '0) begin
        shreg     <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bits_left <= bits_left - 1'b1;
        if (bits_left == BW'(1) && last_flag) begin
          frame_done <= 1'b1;
          last_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rocket_frame_readout.sv
// Directed bench for rocket_frame_readout: MSB-first and LSB-first builds (WIDTH=10, NWORDS=4)
// driven in lockstep, checked against hand-computed frame contents.
module tb_rocket_frame_readout;

  logic        clk50 = 1'b0;
  logic        rst, enable, gclk, load, frame_clr;
  logic [39:0] words_in;
  logic        so_m, ws_m, fd_m, ovr_m;
  logic [2:0]  idx_m;
  logic        so_l, ws_l, fd_l, ovr_l;
  logic [2:0]  idx_l;

  int n_checks = 0;
  int n_fail   = 0;
  int ws_cnt   = 0;
  int fd_cnt   = 0;
  logic [9:0] w_m, w_l;
  logic       first_m, first_l;
  logic [9:0] exp_words [6];

  always #5 clk50 = ~clk50;

  rocket_frame_readout #(.WIDTH(10), .NWORDS(4), .SYNC_EN(1'b1), .SYNC_WORD(10'h3A5),
                         .CKSUM_EN(1'b1), .MSB_FIRST(1'b1), .IDLE_WORD(10'h000)) dut_msb (
    .clk50(clk50), .rst(rst), .enable(enable), .gclk(gclk), .load(load),
    .frame_clr(frame_clr), .words_in(words_in), .serial_out(so_m), .slot_idx(idx_m),
    .word_strobe(ws_m), .frame_done(fd_m), .ovr_err(ovr_m));

  rocket_frame_readout #(.WIDTH(10), .NWORDS(4), .SYNC_EN(1'b1), .SYNC_WORD(10'h3A5),
                         .CKSUM_EN(1'b1), .MSB_FIRST(1'b0), .IDLE_WORD(10'h000)) dut_lsb (
    .clk50(clk50), .rst(rst), .enable(enable), .gclk(gclk), .load(load),
    .frame_clr(frame_clr), .words_in(words_in), .serial_out(so_l), .slot_idx(idx_l),
    .word_strobe(ws_l), .frame_done(fd_l), .ovr_err(ovr_l));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk50);
    ws_cnt += int'(ws_m);
    fd_cnt += int'(fd_m);
  endtask

  // One load followed by nshift gclk pulses; records the first 10 bits seen in emission order.
  task automatic shift_word(input int nshift, input bit gclk_too);
    w_m = '0;
    w_l = '0;
    load = 1'b1;
    gclk = gclk_too;
    tick();
    first_m = so_m;
    first_l = so_l;
    w_m = {w_m[8:0], so_m};
    w_l = {w_l[8:0], so_l};
    load = 1'b0;
    gclk = 1'b0;
    tick();
    for (int i = 1; i <= nshift; i++) begin
      gclk = 1'b1;
      tick();
      if (i <= 9) begin
        w_m = {w_m[8:0], so_m};
        w_l = {w_l[8:0], so_l};
      end
      gclk = 1'b0;
      tick();
    end
  endtask

  initial begin
    int ws0, fd0;
    rst = 1'b1; enable = 1'b1; gclk = 1'b0; load = 1'b0; frame_clr = 1'b0;
    words_in = {10'h3FF, 10'd3, 10'd2, 10'd1};
    tick(); tick();
    check("rst_slot_idx", 32'(idx_m), 32'd0);
    check("rst_serial", 32'(so_m), 32'd0);
    check("rst_strobe", 32'(ws_m), 32'd0);
    check("rst_done", 32'(fd_m), 32'd0);
    check("rst_ovr", 32'(ovr_m), 32'd0);
    rst = 1'b0;
    tick();

    // Full frame: sync, four data words, checksum (1+2+3+0x3FF mod 1024 = 5)
    exp_words = '{10'h3A5, 10'h001, 10'h002, 10'h003, 10'h3FF, 10'h005};
    ws0 = ws_cnt; fd0 = fd_cnt;
    for (int k = 0; k < 6; k++) begin
      shift_word(10, 1'b0);
      check($sformatf("frame1_word%0d", k), 32'(w_m), 32'(exp_words[k]));
      if (k == 4) check("frame1_no_early_done", 32'(fd_cnt - fd0), 32'd0);
    end
    check("frame1_strobes", 32'(ws_cnt - ws0), 32'd4);
    check("frame1_done", 32'(fd_cnt - fd0), 32'd1);
    check("frame1_slot_wrap", 32'(idx_m), 32'd0);
    check("frame1_serial_idle", 32'(so_m), 32'd0);
    check("frame1_no_ovr", 32'(ovr_m), 32'd0);

    // Snapshot isolation: words_in changes after slot 0 do not reach this frame
    shift_word(10, 1'b0);
    check("snap_sync", 32'(w_m), 32'h3A5);
    words_in = {4{10'd9}};
    for (int k = 1; k < 6; k++) begin
      shift_word(10, 1'b0);
      check($sformatf("snap_word%0d", k), 32'(w_m), 32'(exp_words[k]));
    end
    exp_words = '{10'h3A5, 10'h009, 10'h009, 10'h009, 10'h009, 10'h024};
    for (int k = 0; k < 6; k++) begin
      shift_word(10, 1'b0);
      check($sformatf("frame9_word%0d", k), 32'(w_m), 32'(exp_words[k]));
    end

    // Overrun: reload after only 4 shifts
    shift_word(4, 1'b0);
    check("ovr_before", 32'(ovr_m), 32'd0);
    shift_word(10, 1'b0);
    check("ovr_word", 32'(w_m), 32'h009);
    check("ovr_set", 32'(ovr_m), 32'd1);
    tick();
    check("ovr_sticky", 32'(ovr_m), 32'd1);
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    tick();
    check("clr_ovr", 32'(ovr_m), 32'd0);
    check("clr_slot_idx", 32'(idx_m), 32'd0);

    // Disabled load shifts the idle word without advancing the frame
    enable = 1'b0;
    ws0 = ws_cnt;
    shift_word(10, 1'b0);
    enable = 1'b1;
    check("idle_word", 32'(w_m), 32'h000);
    check("idle_slot_idx", 32'(idx_m), 32'd0);
    check("idle_strobes", 32'(ws_cnt - ws0), 32'd0);

    // Simultaneous load and gclk: shift dropped, whole word still emitted
    shift_word(10, 1'b1);
    check("simul_first_msb", 32'(first_m), 32'd1);
    check("simul_first_lsb", 32'(first_l), 32'd1);
    check("simul_word_msb", 32'(w_m), 32'h3A5);
    check("simul_seq_lsb", 32'(w_l), 32'h297);
    check("simul_slot_idx", 32'(idx_m), 32'd1);

    // Reset in the middle of data word 0
    shift_word(4, 1'b0);
    check("pre_rst_bits", 32'(w_m[4:0]), 32'h00);
    rst = 1'b1;
    tick();
    check("mid_rst_slot_idx", 32'(idx_m), 32'd0);
    check("mid_rst_serial", 32'(so_m), 32'd0);
    check("mid_rst_ovr", 32'(ovr_m), 32'd0);
    check("mid_rst_strobe", 32'(ws_m), 32'd0);
    check("mid_rst_done", 32'(fd_m), 32'd0);
    rst = 1'b0;
    tick();
    shift_word(10, 1'b0);
    check("post_rst_sync", 32'(w_m), 32'h3A5);
    check("post_rst_slot_idx", 32'(idx_m), 32'd1);
    check("post_rst_ovr", 32'(ovr_m), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
